// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes, FSM states,
// memory latency bound and small request-classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 4;
  localparam int CNT_W           = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE,
    ERR
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; the unsigned codes are load-only.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request bus plus word-memory port of the load/store unit.
// master: the core/memory environment; slave: the load/store unit itself.
interface lsu_if;

  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic        misalign_o;

  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
    input  rdata_o, done_o, busy_o, misalign_o,
    input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
    output rdata_o, done_o, busy_o, misalign_o,
    output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory word,
// and merges a byte/halfword store into the word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (byte_off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'h0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = word;
    endcase
  end

  // Word stores bypass the merge entirely; only the addressed lane changes otherwise.
  always_comb begin
    merged_word = word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    merged_word[7:0]   = store_data[7:0];
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          default: merged_word[31:24] = store_data[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned addresses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [31:0]       addr_in;
  logic              trap_in;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              rd_en;
  logic              wr_en;
  logic              done;
  logic [31:0]       wdata_out;

  always_comb begin
    addr_in = bus.addr_i;
    trap_in = !funct3_legal(bus.we_i, bus.funct3_i);
`ifdef LSU_MISALIGN_TRAP_EN
    trap_in = trap_in || addr_misaligned(bus.funct3_i, bus.addr_i[1:0]);
`else
    case (bus.funct3_i)
      F3_H, F3_HU: addr_in[0]   = 1'b0;
      F3_W:        addr_in[1:0] = 2'b00;
      default:     ;
    endcase
`endif
  end

  // During WAIT the lane logic sees the live memory word; in WR it sees the captured one.
  assign align_word = (state_q == WAIT) ? bus.mem_rdata_i : word_q;

  lsu_align u_align (
    .funct3      (funct3_q),
    .byte_off    (addr_q[1:0]),
    .word        (align_word),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_i) begin
        we_q     <= bus.we_i;
        funct3_q <= bus.funct3_i;
        addr_q   <= addr_in;
        wdata_q  <= bus.wdata_i;
      end
      // WAIT spans MEM_LATENCY+1 cycles; the word is sampled when the counter reaches zero.
      case (state_q)
        RD: cnt_q <= LAT_INIT;
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            word_q <= bus.mem_rdata_i;
            if (!we_q) rdata_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    wdata_out = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (trap_in)                               state_d = ERR;
          else if (bus.we_i && bus.funct3_i == F3_W) state_d = WR;
          else                                       state_d = RD;
        end
      end
      RD: begin
        rd_en   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = we_q ? WR : DONE;
      end
      WR: begin
        wr_en     = 1'b1;
        wdata_out = merged_word;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (state_q == IDLE && bus.req_i) begin
      mis_q <= addr_misaligned(bus.funct3_i, bus.addr_i[1:0]);
    end
  end

  assign bus.misalign_o = (state_q == ERR) && mis_q;
`else
  assign bus.misalign_o = 1'b0;
`endif

  assign bus.rdata_o     = rdata_q;
  assign bus.done_o      = done;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.mem_rd_en_o = rd_en;
  assign bus.mem_wr_en_o = wr_en;
  assign bus.mem_addr_o  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata_o = wdata_out;

endmodule
